// File: rtl/result_ram_arbiter.sv
// result_ram_arbiter
//   Shares the single-port result SRAM (1-cycle read latency) between the
//   writeback unit (bursts of BURST_LEN writes) and a host read port (single
//   words). Arbitration is per burst, round-robin. Drives all SRAM pins.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   wb_req_i          wb burst request, level, held until wb_gnt_o
//   wb_gnt_o          high for the whole granted burst
//   wb_en_i           write beat valid (honoured only while wb_gnt_o=1)
//   wb_addr_i/data_i  beat address / data
//   wb_abort_o        1-cycle pulse when a burst ends on the gap timeout
//   rd_req_i/addr_i   host read request and address, held until rd_gnt_o
//   rd_gnt_o          1-cycle pulse, same cycle as the accepted request
//   rd_valid_o        1-cycle pulse, rd_data_o holds the read word
//   rd_data_o         registered read data, held until the next read returns
//   ram_*_o/ram_rdata_i  SRAM macro interface
//   busy_o            not idle, or a read still in flight
//   err_proto_o       sticky: wb_en_i seen outside a grant
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrates, one bubble cycle between any two grants
// WB    | writeback unit owns the RAM, beats pass straight through
// RD    | single read access at the captured host address

module result_ram_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int MAX_GAP   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_req_i,
    output logic              wb_gnt_o,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              wb_abort_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              err_proto_o
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int GAP_W  = $clog2(MAX_GAP + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MAX_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_wb_q, last_wb_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                rd_pend_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                err_proto_q;

    logic grant_wb, grant_rd, beat_last, gap_hit;

    // Round-robin tie-break: on a collision the side not served last wins.
    assign grant_wb  = wb_req_i && (!rd_req_i || !last_wb_q);
    assign grant_rd  = rd_req_i && (!wb_req_i ||  last_wb_q);
    assign beat_last = wb_en_i  && (beat_cnt_q == BEAT_LAST);
    assign gap_hit   = !wb_en_i && (gap_cnt_q == GAP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_wb) begin
                    state_d = ST_WB;
                end else if (grant_rd) begin
                    state_d = ST_RD;
                end
            end
            ST_WB: begin
                if (beat_last || gap_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        wb_gnt_o    = 1'b0;
        wb_abort_o  = 1'b0;
        rd_gnt_o    = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        case (state_q)
            ST_IDLE: begin
                // rd_gnt is combinational from rd_req; gate it so every output
                // is low while reset is held.
                rd_gnt_o = rst && grant_rd;
            end
            ST_WB: begin
                wb_gnt_o   = 1'b1;
                wb_abort_o = gap_hit;
                if (wb_en_i) begin
                    ram_en_o    = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_addr_o  = wb_addr_i;
                    ram_wdata_o = wb_data_i;
                end
            end
            ST_RD: begin
                ram_en_o   = 1'b1;
                ram_addr_o = rd_addr_q;
            end
            default: ;
        endcase
    end

    // Burst counters are held at zero outside WB, so they are clear on entry.
    always_comb begin
        beat_cnt_d = '0;
        gap_cnt_d  = '0;
        if (state_q == ST_WB) begin
            if (wb_en_i) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q;
                gap_cnt_d  = gap_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        last_wb_d = last_wb_q;
        rd_addr_d = rd_addr_q;
        if (state_q == ST_IDLE) begin
            if (grant_wb) begin
                last_wb_d = 1'b1;
            end else if (grant_rd) begin
                last_wb_d = 1'b0;
                rd_addr_d = rd_addr_i;
            end
        end
    end

    // Read return: access in RD, RAM data valid the next cycle (rd_pend),
    // registered into rd_data with rd_valid one cycle after that.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_wb_q   <= 1'b0;
            rd_addr_q   <= '0;
            beat_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            err_proto_q <= 1'b0;
        end else begin
            last_wb_q   <= last_wb_d;
            rd_addr_q   <= rd_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rd_pend_q   <= (state_q == ST_RD);
            rd_valid_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= ram_rdata_i;
            end
            err_proto_q <= err_proto_q || (wb_en_i && (state_q != ST_WB));
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = (state_q != ST_IDLE) || rd_pend_q;
    assign err_proto_o = err_proto_q;

endmodule

// File: tb/tb_result_ram_arbiter.sv
module tb_result_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_req, wb_gnt, wb_en, wb_abort;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rd_req, rd_gnt, rd_valid;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        ram_en, ram_we;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        busy, err_proto;

    int checks = 0;
    int failures = 0;

    logic [31:0] sram    [16];
    logic [31:0] exp_mem [16];
    logic [31:0] exp_q   [$];
    logic        mem_clear;

    result_ram_arbiter #(
        .DATA_W(32), .ADDR_W(4), .BURST_LEN(4), .MAX_GAP(8)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_req_i(wb_req), .wb_gnt_o(wb_gnt), .wb_en_i(wb_en),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_abort_o(wb_abort),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .busy_o(busy), .err_proto_o(err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) sram[i] <= 32'h5A5A_0000 | 32'(i);
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) sram[ram_addr] <= ram_wdata;
            else        ram_rdata      <= sram[ram_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        logic [75:0] v;
        v = {wb_gnt, wb_abort, rd_gnt, rd_valid, rd_data, ram_en, ram_we,
             ram_addr, ram_wdata, busy, err_proto};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL %s: outputs=%h required all zero", name, v);
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) if (sram[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d RAM words differ from expected contents", name, bad);
        end
    endtask

    task automatic request_wb();
        bit ok;
        ok = 0;
        tick();
        wb_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_gnt) begin ok = 1; break; end
        end
        wb_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wb_grant_timeout: wb_gnt=%b required 1", wb_gnt);
        end
    endtask

    // Starts in a granted cycle; ends at the cycle after the last beat.
    task automatic drive_beats(input logic [3:0] base, input logic [31:0] dbase, input int n);
        logic [3:0]  a;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            a = base + 4'(i);
            d = dbase + 32'(i);
            wb_en = 1'b1; wb_addr = a; wb_data = d;
            exp_mem[a] = d;
            mid();
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_wdata, wb_gnt, rd_gnt} !== {1'b1, 1'b1, a, d, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL wb_beat%0d: en=%b we=%b addr=%h wdata=%h gnt=%b rd_gnt=%b required 1 1 %h %h 1 0",
                         i, ram_en, ram_we, ram_addr, ram_wdata, wb_gnt, rd_gnt, a, d);
            end
            tick();
        end
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    // Called at the middle of the cycle in which rd_gnt was seen (T).
    task automatic finish_read(input logic [3:0] a);
        logic [31:0] e;
        exp_q.push_back(exp_mem[a]);
        tick();
        rd_req = 1'b0;
        mid();
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, a}) begin
            failures++;
            $display("FAIL rd_access: en=%b we=%b addr=%h required 1 0 %h", ram_en, ram_we, ram_addr, a);
        end
        tick(); mid();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_early: rd_valid=%b at T+2 required 0", rd_valid);
        end
        tick(); mid();
        e = '0;
        checks++;
        if (rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_valid: rd_valid=%b at T+3 required 1", rd_valid);
        end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
                failures++;
                $display("FAIL rd_data: rd_data=%h required %h", rd_data, e);
            end
        end
        tick(); mid();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== e) begin
            failures++;
            $display("FAIL rd_hold: rd_valid=%b rd_data=%h required 0 %h", rd_valid, rd_data, e);
        end
    endtask

    task automatic wait_rd_gnt();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (rd_gnt) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rd_grant_timeout: rd_gnt=%b required 1", rd_gnt);
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        tick();
        rd_req = 1'b1; rd_addr = a;
        wait_rd_gnt();
        if (rd_gnt) finish_read(a);
        rd_req = 1'b0;
    endtask

    task automatic check_idle_after_burst(input string name);
        mid();
        checks++;
        if (wb_gnt !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: wb_gnt=%b busy=%b required 0 0", name, wb_gnt, busy);
        end
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_clear = 1'b1;
        wb_req = 0; wb_en = 0; wb_addr = '0; wb_data = '0; rd_req = 0; rd_addr = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h5A5A_0000 | 32'(i);
        tick(); tick();
        mid();
        check_all_zero("reset_outputs");
        tick();
        rst = 1'b1; mem_clear = 1'b0;
        mid();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_wb_burst();
        request_wb();
        drive_beats(4'd0, 32'hAAAA_00A0, 4);
        check_idle_after_burst("burst_end_idle");
        check_mem("burst_ram_contents");
    endtask

    task automatic test_read();
        do_read(4'd2);
    endtask

    task automatic test_tie();
        reset_dut();
        wb_req = 1'b1; rd_req = 1'b1; rd_addr = 4'd1;
        mid();
        checks++;
        if (rd_gnt !== 1'b0) begin
            failures++;
            $display("FAIL tie1_rd_gnt: rd_gnt=%b required 0", rd_gnt);
        end
        tick();
        checks++;
        if (wb_gnt !== 1'b1) begin
            failures++;
            $display("FAIL tie1_wb_gnt: wb_gnt=%b required 1", wb_gnt);
        end
        wb_req = 1'b0;
        drive_beats(4'd4, 32'hBBBB_00B0, 4);
        wait_rd_gnt();
        if (rd_gnt) finish_read(4'd1);
        rd_req = 1'b0;
        // WB-only burst so WB is the last served side
        request_wb();
        drive_beats(4'd8, 32'hCCCC_00C0, 4);
        wb_req = 1'b1; rd_req = 1'b1; rd_addr = 4'd5;
        mid();
        checks++;
        if (rd_gnt !== 1'b1) begin
            failures++;
            $display("FAIL tie2_rd_gnt: rd_gnt=%b required 1", rd_gnt);
        end
        exp_q.push_back(exp_mem[5]);
        tick();
        rd_req = 1'b0;
        mid();
        checks++;
        if ({ram_en, ram_we, ram_addr, wb_gnt} !== {1'b1, 1'b0, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL tie2_rd_access: en=%b we=%b addr=%h wb_gnt=%b required 1 0 5 0",
                     ram_en, ram_we, ram_addr, wb_gnt);
        end
        tick(); mid();
        checks++;
        if (wb_gnt !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL tie2_bubble: wb_gnt=%b rd_valid=%b required 0 0", wb_gnt, rd_valid);
        end
        tick();
        checks++;
        if (wb_gnt !== 1'b1 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL tie2_t3: wb_gnt=%b rd_valid=%b required 1 1", wb_gnt, rd_valid);
        end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
                failures++;
                $display("FAIL tie2_rd_data: rd_data=%h required %h", rd_data, e);
            end
        end
        wb_req = 1'b0;
        drive_beats(4'd12, 32'hDDDD_00D0, 4);
        check_idle_after_burst("tie2_burst_end");
        do_read(4'd13);
    endtask

    task automatic test_abort();
        int bad;
        request_wb();
        drive_beats(4'd14, 32'hEEEE_00E0, 2);
        wb_addr = 4'd3; wb_data = 32'hBAD0_BAD0;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            mid();
            if (wb_abort !== (k == 8) || wb_gnt !== 1'b1 || ram_en !== 1'b0) begin
                bad++;
                $display("FAIL abort_gap%0d: abort=%b gnt=%b ram_en=%b required %b 1 0",
                         k, wb_abort, wb_gnt, ram_en, (k == 8));
            end
            tick();
        end
        checks++;
        if (bad != 0) failures++;
        wb_addr = '0; wb_data = '0;
        mid();
        checks++;
        if (wb_gnt !== 1'b0 || wb_abort !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: wb_gnt=%b wb_abort=%b required 0 0", wb_gnt, wb_abort);
        end
        check_mem("abort_ram_contents");
    endtask

    task automatic test_err_proto();
        mid();
        checks++;
        if (err_proto !== 1'b0) begin
            failures++;
            $display("FAIL err_initial: err_proto=%b required 0", err_proto);
        end
        tick();
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'hDEAD_BEEF;
        mid();
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL err_no_write: ram_en=%b ram_we=%b required 0 0", ram_en, ram_we);
        end
        tick();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        mid();
        checks++;
        if (err_proto !== 1'b1) begin
            failures++;
            $display("FAIL err_set: err_proto=%b required 1", err_proto);
        end
        tick(); tick(); tick(); mid();
        checks++;
        if (err_proto !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err_proto=%b required 1", err_proto);
        end
        check_mem("err_ram_contents");
    endtask

    task automatic test_reset_midway();
        int bad;
        // reset in the RAM-access cycle of a read
        tick();
        rd_req = 1'b1; rd_addr = 4'd0;
        wait_rd_gnt();
        tick();
        rd_req = 1'b0;
        #1 rst = 1'b0;
        #1 check_all_zero("reset_during_read");
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            mid();
            if (rd_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL dropped_read: rd_valid seen %0d times required 0", bad);
        end
        // reset mid-burst with a read held off
        request_wb();
        drive_beats(4'd0, 32'hF0F0_0000, 2);
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h1234_5678;
        rd_req = 1'b1; rd_addr = 4'd3;
        #1 rst = 1'b0;
        #1 check_all_zero("reset_mid_burst");
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick();
        rst = 1'b1;
        wait_rd_gnt();
        if (rd_gnt) finish_read(4'd3);
        rd_req = 1'b0;
        request_wb();
        drive_beats(4'd8, 32'h7777_0070, 4);
        check_idle_after_burst("post_reset_burst_end");
        check_mem("post_reset_ram_contents");
    endtask

    initial begin
        test_reset();
        test_wb_burst();
        test_read();
        test_tie();
        test_abort();
        test_err_proto();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
